// File: rtl/kb_turn_arbiter.sv
// Turn-based arbiter between two PS/2 keyboard front-ends.
// Moves per-player cursors and raises a shot interrupt with ack handshake.
module kb_turn_arbiter #(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [1:0] kb0_dir,
    input  logic       kb0_fire,
    input  logic       kb0_done,
    input  logic [1:0] kb1_dir,
    input  logic       kb1_fire,
    input  logic       kb1_done,
    input  logic       turn_en,
    input  logic       new_game,
    input  logic       cpu_ack,
    output logic       irq,
    output logic       irq_player,
    output logic [3:0] irq_x,
    output logic [3:0] irq_y,
    output logic       turn,
    output logic [3:0] cur0_x,
    output logic [3:0] cur0_y,
    output logic [3:0] cur1_x,
    output logic [3:0] cur1_y,
    output logic [7:0] ignored_cnt
);

    localparam logic [3:0] X_MAX = 4'(GRID_W - 1);
    localparam logic [3:0] Y_MAX = 4'(GRID_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REQ
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       act_done;
    logic       act_fire;
    logic [1:0] act_dir;
    logic [3:0] ax;
    logic [3:0] ay;
    logic [3:0] nx;
    logic [3:0] ny;
    logic       accept;
    logic       fire_acc;
    logic       move_acc;
    logic       ack_req;
    logic [1:0] ign_n;
    logic [8:0] cnt_sum;
    logic [7:0] cnt_nxt;

    assign act_done = turn ? kb1_done : kb0_done;
    assign act_fire = turn ? kb1_fire : kb0_fire;
    assign act_dir  = turn ? kb1_dir  : kb0_dir;
    assign ax       = turn ? cur1_x   : cur0_x;
    assign ay       = turn ? cur1_y   : cur0_y;

    assign accept   = (state_q == S_WAIT) && act_done;
    assign fire_acc = accept && act_fire;
    assign move_acc = accept && !act_fire;
    assign ack_req  = (state_q == S_REQ) && cpu_ack;

    // Every strobe that is not the accepted one counts as ignored.
    assign ign_n   = {1'b0, kb0_done} + {1'b0, kb1_done} - {1'b0, accept};
    assign cnt_sum = {1'b0, ignored_cnt} + {7'b0, ign_n};
    assign cnt_nxt = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];

    // Clamped single-cell step of the active cursor.
    always_comb begin
        nx = ax;
        ny = ay;
        unique case (act_dir)
            2'b00: if (ay != 4'd0)  ny = ay - 4'd1;
            2'b01: if (ay != Y_MAX) ny = ay + 4'd1;
            2'b10: if (ax != 4'd0)  nx = ax - 4'd1;
            2'b11: if (ax != X_MAX) nx = ax + 4'd1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic; new_game forces IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (turn_en) state_d = S_WAIT;
            S_WAIT: begin
                if (fire_acc)      state_d = S_REQ;
                else if (!turn_en) state_d = S_IDLE;
            end
            S_REQ: if (cpu_ack) state_d = turn_en ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (new_game) state_d = S_IDLE;
    end

    // FSM outputs: a shot is pending exactly while in REQ.
    always_comb begin
        irq = (state_q == S_REQ);
    end

    // Cursor registers: only the active player's cursor moves.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cur0_x <= '0;
            cur0_y <= '0;
            cur1_x <= '0;
            cur1_y <= '0;
        end else if (new_game) begin
            cur0_x <= '0;
            cur0_y <= '0;
            cur1_x <= '0;
            cur1_y <= '0;
        end else if (move_acc) begin
            if (turn) begin
                cur1_x <= nx;
                cur1_y <= ny;
            end else begin
                cur0_x <= nx;
                cur0_y <= ny;
            end
        end
    end

    // Turn, shot payload and ignored-strobe counter.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            turn        <= 1'b0;
            irq_player  <= 1'b0;
            irq_x       <= '0;
            irq_y       <= '0;
            ignored_cnt <= '0;
        end else if (new_game) begin
            turn        <= 1'b0;
            irq_player  <= 1'b0;
            irq_x       <= '0;
            irq_y       <= '0;
            ignored_cnt <= '0;
        end else begin
            ignored_cnt <= cnt_nxt;
            if (ack_req) turn <= ~turn;
            if (fire_acc) begin
                irq_player <= turn;
                irq_x      <= ax;
                irq_y      <= ay;
            end
        end
    end

endmodule

// File: doc/kb_turn_arbiter.md
# kb_turn_arbiter

Turn-based arbiter between two PS/2 keyboard front-ends in the Battleship design. It takes the one-cycle `done` events, with `direction`/`fire`, from each player's keyboard block. It moves a per-player cursor on the game grid and accepts input only from the player whose turn it is. Each shot goes to the processor over a level interrupt with a request/acknowledge handshake.

## Interface
- `GRID_W`, default 10: grid columns; cursor x range 0..GRID_W-1.
- `GRID_H`, default 10: grid rows; cursor y range 0..GRID_H-1.
- `sys_clk`  in  1  system clock.
- `rst_n`  in  1  reset: asynchronous, active-low. Clock is `sys_clk`.
- `kb0_dir`  in  2  player 0 direction: 00 up, 01 down, 10 left, 11 right.
- `kb0_fire`  in  1  player 0 fire qualifier.
- `kb0_done`  in  1  player 0 event strobe, one `sys_clk` cycle.
- `kb1_dir`, `kb1_fire`, `kb1_done`  in  2/1/1  same for player 1.
- `turn_en`  in  1  processor permits new input to be accepted.
- `new_game`  in  1  one-cycle pulse: restart game state.
- `cpu_ack`  in  1  processor has consumed the shot.
- `irq`  out  1  shot pending.
- `irq_player`  out  1  player that fired.
- `irq_x`, `irq_y`  out  4/4  shot coordinates.
- `turn`  out  1  active player.
- `cur0_x`, `cur0_y`, `cur1_x`, `cur1_y`  out  4 each  player cursors.
- `ignored_cnt`  out  8  saturating count of discarded `done` strobes.

## Operation
- FSM states: IDLE, WAIT, REQ.
  - IDLE→WAIT when `turn_en`=1.
  - WAIT→IDLE when `turn_en`=0.
  - WAIT→REQ on accepted fire.
  - REQ→WAIT on `cpu_ack` if `turn_en`=1; otherwise REQ→IDLE.
- Event sampling: `dir` and `fire` are sampled in the same cycle as their `done`. They are don't-care otherwise.
- Active strobe: `kbN_done` with N == `turn`.
- Accepted event: an active strobe in WAIT.
  - `fire`=1: latch `irq_player`=`turn` and `irq_x`/`irq_y` = active cursor. Assert `irq`. Go to REQ. Cursor unchanged; `dir` ignored.
  - `fire`=0: move the active cursor one cell per `dir`.
    - Moves clamp at edges, no wrap: up at y=0, down at y=GRID_H-1, left at x=0, right at x=GRID_W-1 leave the cursor unchanged.
    - Up decrements y; right increments x.
- Ignored strobes: every `done` not accepted, including inactive player, IDLE, REQ, and the inactive half of simultaneous strobes.
  - Each ignored strobe increments `ignored_cnt` by 1, saturating at 255.
  - Both players strobing in a cycle where neither is accepted adds 2, still saturating.
- Simultaneous `kb0_done` and `kb1_done` in WAIT: only the active player's event is processed; the other adds 1 to `ignored_cnt`.
- Handshake: in REQ, `irq`, `irq_player`, `irq_x` and `irq_y` hold stable until `cpu_ack` is sampled high. Then:
  - `irq` deasserts.
  - `turn` toggles.
  - The inactive player's cursor is untouched.
  - `cpu_ack` outside REQ has no effect.
- `turn_en` falling during REQ does not cancel the pending shot; the handshake completes normally.
- `new_game` has priority over all other inputs in its cycle:
  - Cursors go to (0,0), `turn` to 0, `irq` to 0, FSM to IDLE.
  - `irq_x`/`irq_y`/`irq_player` go to 0; `ignored_cnt` clears.
  - Strobes in that cycle are discarded uncounted.

## Timing
- All state is registered on `sys_clk` rising edge.
- Reset values: FSM IDLE; `irq`=0, `irq_player`=0, `irq_x`=`irq_y`=0; `turn`=0; all cursors 0; `ignored_cnt`=0.
- Move latency: accepted move strobe in cycle N; new cursor visible in N+1.
- Fire latency: accepted fire in cycle N; `irq`=1 with coordinates valid in N+1. The coordinates equal the cursor value at N.
- Back-to-back: a move at N and a fire at N+1 reports the post-move cursor.
- Ack latency: `cpu_ack` high in REQ at cycle M; `irq`=0 and `turn` toggled in M+1. A strobe in M+1 from the new active player is accepted.
- A strobe in cycle M itself is ignored and counted.
- Minimum `irq` high time is 1 cycle: `cpu_ack` may be held high permanently.
- Asynchronous reset mid-REQ drops the shot; no `irq` after release.

## Test plan
- Moves with clamp:
  - Stimulus: `turn_en`=1; player 0 sends right×3, down×2, then left×5.
  - Required: cursor 0 after each strobe (1,0),(2,0),(3,0),(3,1),(3,2),(2,2),(1,2),(0,2),(0,2),(0,2); `ignored_cnt`=0.
- Edge clamp at max:
  - Stimulus: player 0 sends right×12, then down×12.
  - Required: cur0=(9,9), stable after the 9th strobe of each.
- Fire handshake:
  - Stimulus: cur0=(4,7); fire at N; `cpu_ack` at N+5.
  - Required: `irq`=1 from N+1 to N+5 with `irq_player`=0, `irq_x`=4, `irq_y`=7; `irq`=0 and `turn`=1 at N+6.
- Arbitration:
  - Stimulus: `turn`=0; `kb0_done` (right) and `kb1_done` (down) in the same cycle; then `kb1_done` alone.
  - Required: cur0 x+1; cur1 unchanged; `ignored_cnt`=2.
- Ignore and saturate:
  - Stimulus: 300 strobes from player 0 during REQ.
  - Required: `ignored_cnt`=255; `irq` coordinates unchanged; cursors unchanged.
- new_game and reset:
  - Stimulus: `new_game` during REQ with cur1=(5,5).
  - Required: next cycle `irq`=0, `turn`=0, all cursors (0,0), FSM IDLE.
  - Stimulus: async `rst_n` low mid-REQ.
  - Required: same values, applied immediately.
